// File: rtl/ram_bytes.sv
// Byte-addressed RAM with a parametrised word width. Accesses of any size can start at any byte address.
// After reset a clear sequencer zeroes the array one word-group per cycle. ready rises when the clear is done.
//
// state | meaning
// CLEAR | zeroing the array from clr_ptr; requests ignored, ready=0
// READY | servicing reads/writes; left only on reset
module ram_bytes #(
    parameter int addrSize     = 9,
    parameter int wordBytes    = 4,
    parameter int clearOnReset = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     output_en,
    input  logic [addrSize-1:0]      addr,
    input  logic [2:0]               size,
    input  logic [8*wordBytes-1:0]   data_in,
    input  logic                     write_rq,
    output logic [8*wordBytes-1:0]   data_out,
    output logic                     ready
);

    localparam int depth   = 2**addrSize;
    localparam int wordLog = $clog2(wordBytes);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state;
    logic [addrSize-1:0] clr_ptr;
    logic [7:0]          mem [depth];

    logic [4:0]          n_bytes;
    logic [wordBytes-1:0] byte_en;
    logic [addrSize-1:0] byte_addr [wordBytes];

    // Sizes larger than a word are clamped to a full word; byte addresses wrap at the top of the array.
    always_comb begin
        if (int'(size) >= wordLog) n_bytes = 5'(wordBytes);
        else                       n_bytes = 5'd1 << size;
        for (int k = 0; k < wordBytes; k++) begin
            byte_en[k]   = (5'(k) < n_bytes);
            byte_addr[k] = addr + addrSize'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            ready    <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    data_out <= '0;
                    ready    <= 1'b0;
                    if (clearOnReset != 0) begin
                        for (int k = 0; k < wordBytes; k++)
                            mem[clr_ptr + addrSize'(k)] <= 8'h00;
                        clr_ptr <= clr_ptr + addrSize'(wordBytes);
                        if (clr_ptr == addrSize'(depth - wordBytes)) begin
                            state <= READY;
                            ready <= 1'b1;
                        end
                    end else begin
                        state <= READY;
                    end
                end
                READY: begin
                    ready <= 1'b1;
                    if (write_rq) begin
                        for (int k = 0; k < wordBytes; k++)
                            if (byte_en[k]) mem[byte_addr[k]] <= data_in[8*k +: 8];
                    end
                    // Read and write share addr/size, so every enabled byte of a simultaneous write overlaps the read.
                    if (output_en) begin
                        for (int k = 0; k < wordBytes; k++) begin
                            if (!byte_en[k])   data_out[8*k +: 8] <= 8'h00;
                            else if (write_rq) data_out[8*k +: 8] <= data_in[8*k +: 8];
                            else               data_out[8*k +: 8] <= mem[byte_addr[k]];
                        end
                    end else begin
                        data_out <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bytes.sv
// Self-checking bench for ram_bytes: a byte-array reference model feeds a scoreboard of expected read data.
// A second instance with clearOnReset=0 covers the keep-contents reset path.
module tb_ram_bytes;

    logic        clk = 1'b0;
    logic        reset, reset_nc, output_en, write_rq;
    logic [8:0]  addr;
    logic [2:0]  size;
    logic [31:0] data_in;
    logic [31:0] data_out, data_out_nc;
    logic        ready, ready_nc;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [512];

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq [$];

    always #5 clk = ~clk;

    ram_bytes #(.addrSize(9), .wordBytes(4), .clearOnReset(1)) dut (
        .clk(clk), .reset(reset), .output_en(output_en), .addr(addr), .size(size),
        .data_in(data_in), .write_rq(write_rq), .data_out(data_out), .ready(ready)
    );

    ram_bytes #(.addrSize(9), .wordBytes(4), .clearOnReset(0)) dut_nc (
        .clk(clk), .reset(reset_nc), .output_en(output_en), .addr(addr), .size(size),
        .data_in(data_in), .write_rq(write_rq), .data_out(data_out_nc), .ready(ready_nc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [8:0] a, input logic [2:0] s);
        logic [31:0] r = '0;
        int n = (s >= 3'd2) ? 4 : (1 << s);
        for (int k = 0; k < 4; k++)
            if (k < n) r[8*k +: 8] = model[(int'(a) + k) % 512];
        return r;
    endfunction

    task automatic model_write(input logic [8:0] a, input logic [2:0] s, input logic [31:0] d);
        int n = (s >= 3'd2) ? 4 : (1 << s);
        for (int k = 0; k < 4; k++)
            if (k < n) model[(int'(a) + k) % 512] = d[8*k +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) model[i] = 8'h00;
    endtask

    task automatic pop_check();
        sb_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, data_out, e.exp);
        end
    endtask

    task automatic do_write(input logic [8:0] a, input logic [2:0] s, input logic [31:0] d);
        addr = a; size = s; data_in = d; write_rq = 1'b1; output_en = 1'b0;
        model_write(a, s, d);
        step();
        write_rq = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] a, input logic [2:0] s, input logic [31:0] exp, input string tag);
        addr = a; size = s; write_rq = 1'b0; output_en = 1'b1;
        sbq.push_back('{tag, exp});
        step();
        output_en = 1'b0;
        pop_check();
    endtask

    task automatic do_write_read(input logic [8:0] a, input logic [2:0] s, input logic [31:0] d,
                                 input logic [31:0] exp, input string tag);
        addr = a; size = s; data_in = d; write_rq = 1'b1; output_en = 1'b1;
        model_write(a, s, d);
        sbq.push_back('{tag, exp});
        step();
        write_rq = 1'b0; output_en = 1'b0;
        pop_check();
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        do begin
            step();
            cnt++;
        end while (!ready && cnt < 300);
        chk(tag, cnt, 128);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; reset_nc = 1'b1;
        output_en = 1'b0; write_rq = 1'b0;
        addr = '0; size = '0; data_in = '0;
        step();
        step();
        chk("rst_ready", ready, 0);
        chk("rst_dout", data_out, 0);
        reset = 1'b0; reset_nc = 1'b0;

        // requests while clearing must be ignored
        addr = 9'h100; size = 3'd2; data_in = 32'hA5A5A5A5; write_rq = 1'b1; output_en = 1'b1;
        step();
        chk("clear_dout", data_out, 0);
        begin
            int cnt = 1;
            while (!ready && cnt < 300) begin
                step();
                cnt++;
            end
            chk("clear_len", cnt, 128);
        end
        write_rq = 1'b0; output_en = 1'b0;
        chk("ready_dout", data_out, 0);
        model_clear();

        do_read(9'h000, 3'd2, 32'h0, "zero_000");
        do_read(9'h1FC, 3'd2, 32'h0, "zero_1fc");
        do_read(9'h100, 3'd2, 32'h0, "clear_ign_wr");

        do_write(9'h010, 3'd2, 32'hDDCCBBAA);
        do_read(9'h010, 3'd2, 32'hDDCCBBAA, "word_rd");
        do_read(9'h012, 3'd0, 32'h000000CC, "byte_rd");
        do_read(9'h011, 3'd1, 32'h0000CCBB, "half_rd");

        do_write(9'h1FE, 3'd2, 32'h44332211);
        do_read(9'h1FE, 3'd2, 32'h44332211, "wrap_word");
        do_read(9'h000, 3'd0, 32'h00000033, "wrap_b0");
        do_read(9'h1FF, 3'd1, 32'h00003322, "wrap_half");

        do_write_read(9'h020, 3'd1, 32'h1234BEEF, 32'h0000BEEF, "wr_rd_same");
        step();
        chk("idle_dout", data_out, 0);
        do_read(9'h020, 3'd2, model_read(9'h020, 3'd2), "wr_rd_stored");

        // only byte 0 written; size=3 reads clamp to a full word
        do_write(9'h030, 3'd0, 32'hFFFFFFFF);
        do_read(9'h030, 3'd3, 32'h000000FF, "clamp_rd");
        do_write(9'h034, 3'd7, 32'h87654321);
        do_read(9'h034, 3'd2, 32'h87654321, "clamp_wr");

        for (int i = 0; i < 10; i++) begin
            logic [8:0]  a;
            logic [2:0]  s;
            logic [31:0] d;
            a = 9'($urandom_range(0, 511));
            s = 3'($urandom_range(0, 3));
            d = $urandom;
            do_write(a, s, d);
            a = a + 9'($urandom_range(0, 3));
            do_read(a, 3'd2, model_read(a, 3'd2), "rand_rd");
        end

        // reset in READY, then again 50 cycles into the clear
        reset = 1'b1;
        step();
        reset = 1'b0;
        addr = 9'h080; size = 3'd2; data_in = 32'h5A5A5A5A; write_rq = 1'b1; output_en = 1'b1;
        for (int i = 0; i < 50; i++) step();
        chk("mid_ready", ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready("reclear_len");
        write_rq = 1'b0; output_en = 1'b0;
        model_clear();
        do_read(9'h010, 3'd2, 32'h0, "reclr_010");
        do_read(9'h080, 3'd2, 32'h0, "reclr_080");
        do_read(9'h1FE, 3'd2, 32'h0, "reclr_wrap");

        // keep-contents instance: data survives reset, ready on second edge after release
        do_write(9'h040, 3'd2, 32'h12345678);
        reset_nc = 1'b1;
        step();
        reset_nc = 1'b0;
        step();
        chk("nc_ready_e1", ready_nc, 0);
        step();
        chk("nc_ready_e2", ready_nc, 1);
        addr = 9'h040; size = 3'd2; output_en = 1'b1;
        step();
        output_en = 1'b0;
        chk("nc_keep", data_out_nc, 32'h12345678);
        chk("nc_main_rd", data_out, model_read(9'h040, 3'd2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
